// File: rtl/jt12_pg_ring_if.sv
// Operator-slot bundle for the phase-generator ring.
// master drives the per-slot inputs; slave is the ring core.
interface jt12_pg_ring_if #(
    parameter int SW   = 5,
    parameter int PHW  = 17,
    parameter int OUTW = 10
);
    logic            clk_en;
    logic            sync;
    logic [PHW-1:0]  phinc_I;
    logic [5:0]      detune_I;
    logic [3:0]      mul_I;
    logic            pg_rst_I;
    logic            pg_stop_I;
    logic [SW-1:0]   slot;
    logic [OUTW-1:0] phase_out;
    logic [SW-1:0]   phase_slot;

    modport master (
        output clk_en, sync,
        output phinc_I, detune_I, mul_I,
        output pg_rst_I, pg_stop_I,
        input  slot, phase_out, phase_slot
    );

    modport slave (
        input  clk_en, sync,
        input  phinc_I, detune_I, mul_I,
        input  pg_rst_I, pg_stop_I,
        output slot, phase_out, phase_slot
    );
endinterface

// File: rtl/jt12_pg_ring.sv
// Time-multiplexed phase generator: one accumulator per operator slot,
// detune/multiply on the increment, slot-tagged output after OUT_LAT ticks.
module jt12_pg_ring #(
    parameter int SLOTS   = 24,
    parameter int SW      = 5,
    parameter int PHW     = 17,
    parameter int ACCW    = 20,
    parameter int OUTW    = 10,
    parameter int OUT_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    jt12_pg_ring_if.slave pg
);

    logic [SW-1:0]   slot_q;
    logic [SW-1:0]   slot_nxt;
    logic [ACCW-1:0] acc [SLOTS];

    logic [PHW-1:0]  d;
    logic [ACCW-1:0] d_w;
    logic [ACCW-1:0] mul_w;
    logic [ACCW-1:0] inc;
    logic [ACCW-1:0] acc_cur;
    logic [ACCW-1:0] acc_nxt;

    // Stage 0 captures the fresh value at the update edge; the
    // remaining OUT_LAT stages provide the visible latency.
    logic [OUTW-1:0] ph_q [OUT_LAT+1];
    logic [SW-1:0]   sl_q [OUT_LAT+1];

    assign d     = pg.phinc_I + PHW'($signed(pg.detune_I));
    assign d_w   = ACCW'(d);
    assign mul_w = ACCW'(pg.mul_I);
    assign inc   = (pg.mul_I == 4'd0) ? (d_w >> 1) : (d_w * mul_w);

    assign acc_cur = acc[slot_q];

    always_comb begin
        acc_nxt = acc_cur + inc;
        if (pg.pg_rst_I)
            acc_nxt = '0;
        else if (pg.pg_stop_I)
            acc_nxt = acc_cur;
    end

    always_comb begin
        slot_nxt = slot_q + 1'b1;
        if (pg.sync || slot_q == SW'(SLOTS - 1))
            slot_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            for (int i = 0; i < SLOTS; i++)
                acc[i] <= '0;
            for (int i = 0; i <= OUT_LAT; i++) begin
                ph_q[i] <= '0;
                sl_q[i] <= '0;
            end
        end else if (pg.clk_en) begin
            slot_q      <= slot_nxt;
            acc[slot_q] <= acc_nxt;
            ph_q[0]     <= acc_nxt[ACCW-1 -: OUTW];
            sl_q[0]     <= slot_q;
            for (int i = 1; i <= OUT_LAT; i++) begin
                ph_q[i] <= ph_q[i-1];
                sl_q[i] <= sl_q[i-1];
            end
        end
    end

    assign pg.slot       = slot_q;
    assign pg.phase_out  = ph_q[OUT_LAT];
    assign pg.phase_slot = sl_q[OUT_LAT];

endmodule
